// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: MEM stage has priority,
// the host is force-granted after MAX_WAIT lost cycles, and read data is steered back to the owner.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_halted,
  input  logic              i_p_req,
  input  logic              i_p_we,
  input  logic [ADDR_W-1:0] i_p_addr,
  input  logic [DATA_W-1:0] i_p_wdata,
  output logic              o_p_stall,
  output logic              o_p_valid,
  output logic [DATA_W-1:0] o_p_rdata,
  input  logic              i_h_req,
  input  logic              i_h_we,
  input  logic [ADDR_W-1:0] i_h_addr,
  input  logic [DATA_W-1:0] i_h_wdata,
  output logic              o_h_gnt,
  output logic              o_h_valid,
  output logic [DATA_W-1:0] o_h_rdata,
  output logic              o_m_en,
  output logic              o_m_we,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [DATA_W-1:0] o_m_wdata,
  input  logic [DATA_W-1:0] i_m_rdata
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P_RD = 2'd1,
    H_RD = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_wcnt;
  logic       w_force;
  logic       w_p_gnt;
  logic       w_h_gnt;

  assign w_force = i_h_req && (r_wcnt == WAIT_MAX);

  // While halted the pipeline is ignored entirely; otherwise a starved host preempts it once.
  always_comb begin
    w_p_gnt = 1'b0;
    w_h_gnt = 1'b0;
    if (i_halted) begin
      w_h_gnt = i_h_req;
    end else if (w_force) begin
      w_h_gnt = 1'b1;
    end else if (i_p_req) begin
      w_p_gnt = 1'b1;
    end else begin
      w_h_gnt = i_h_req;
    end
  end

  assign o_p_stall = i_p_req && !i_halted && !w_p_gnt;
  assign o_h_gnt   = w_h_gnt;

  always_comb begin
    o_m_en    = w_p_gnt || w_h_gnt;
    o_m_we    = 1'b0;
    o_m_addr  = '0;
    o_m_wdata = '0;
    if (w_p_gnt) begin
      o_m_we    = i_p_we;
      o_m_addr  = i_p_addr;
      o_m_wdata = i_p_wdata;
    end else if (w_h_gnt) begin
      o_m_we    = i_h_we;
      o_m_addr  = i_h_addr;
      o_m_wdata = i_h_wdata;
    end
  end

  // Counts consecutive lost host cycles; any grant or a dropped request restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wcnt <= '0;
    end else if (w_h_gnt || !i_h_req) begin
      r_wcnt <= '0;
    end else if (r_wcnt != WAIT_MAX) begin
      r_wcnt <= r_wcnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = IDLE;
    if (w_p_gnt && !i_p_we) begin
      w_state_next = P_RD;
    end else if (w_h_gnt && !i_h_we) begin
      w_state_next = H_RD;
    end
  end

  always_comb begin
    o_p_valid = (r_state == P_RD);
    o_h_valid = (r_state == H_RD);
    o_p_rdata = o_p_valid ? i_m_rdata : '0;
    o_h_rdata = o_h_valid ? i_m_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, then random traffic checked against
// a cycle-level reference of the grant rules with a shadow copy of memory.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst, halted;
  logic        p_req, p_we, h_req, h_we;
  logic [9:0]  p_addr, h_addr;
  logic [31:0] p_wdata, h_wdata;
  logic        p_stall, p_valid, h_gnt, h_valid;
  logic [31:0] p_rdata, h_rdata;
  logic        m_en, m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_rst(rst), .i_halted(halted),
    .i_p_req(p_req), .i_p_we(p_we), .i_p_addr(p_addr), .i_p_wdata(p_wdata),
    .o_p_stall(p_stall), .o_p_valid(p_valid), .o_p_rdata(p_rdata),
    .i_h_req(h_req), .i_h_we(h_we), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
    .o_h_gnt(h_gnt), .o_h_valid(h_valid), .o_h_rdata(h_rdata),
    .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port data memory with registered read.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  typedef struct {
    logic        rst, halted, preq, pwe;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic        hreq, hwe;
    logic [9:0]  haddr;
    logic [31:0] hwdata;
    logic        e_stall, e_gnt, e_pv, e_hv;
    logic [31:0] e_data;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] shadow [1024];
  int          hw = 0;
  logic        mp_v = 1'b0, mh_v = 1'b0;
  logic [31:0] mp_d = '0, mh_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, hl, pq, pw, input logic [9:0] pa,
                              input logic [31:0] pd, input logic hq, hwr,
                              input logic [9:0] ha, input logic [31:0] hd,
                              input logic es, eg, epv, ehv, input logic [31:0] ed);
    vec_t v;
    v.rst = r; v.halted = hl; v.preq = pq; v.pwe = pw; v.paddr = pa; v.pwdata = pd;
    v.hreq = hq; v.hwe = hwr; v.haddr = ha; v.hwdata = hd;
    v.e_stall = es; v.e_gnt = eg; v.e_pv = epv; v.e_hv = ehv; v.e_data = ed;
    return v;
  endfunction

  task automatic cyc(input vec_t v, input bit use_tbl, input int idx);
    logic pg, hg, forced;
    rst = v.rst; halted = v.halted;
    p_req = v.preq; p_we = v.pwe; p_addr = v.paddr; p_wdata = v.pwdata;
    h_req = v.hreq; h_we = v.hwe; h_addr = v.haddr; h_wdata = v.hwdata;
    #2;
    // Host that has lost MAX_WAIT cycles in a row must win this one.
    forced = v.hreq && (hw >= MAX_WAIT);
    pg = 1'b0; hg = 1'b0;
    if (v.halted)      hg = v.hreq;
    else if (forced)   hg = 1'b1;
    else if (v.preq)   pg = 1'b1;
    else               hg = v.hreq;
    chk("p_stall", p_stall, v.preq && !v.halted && !pg);
    chk("h_gnt",   h_gnt,   hg);
    chk("m_en",    m_en,    pg || hg);
    chk("m_we",    m_we,    pg ? v.pwe : (hg ? v.hwe : 1'b0));
    chk("m_addr",  m_addr,  pg ? v.paddr : (hg ? v.haddr : 10'd0));
    chk("m_wdata", m_wdata, pg ? v.pwdata : (hg ? v.hwdata : 32'd0));
    if (use_tbl) begin
      chk("tbl_p_stall", p_stall, v.e_stall);
      chk("tbl_h_gnt",   h_gnt,   v.e_gnt);
    end
    mp_v = !v.rst && pg && !v.pwe;
    mh_v = !v.rst && hg && !v.hwe;
    mp_d = mp_v ? shadow[v.paddr] : 32'd0;
    mh_d = mh_v ? shadow[v.haddr] : 32'd0;
    if (pg && v.pwe) shadow[v.paddr] = v.pwdata;
    if (hg && v.hwe) shadow[v.haddr] = v.hwdata;
    hw = (v.rst || hg || !v.hreq) ? 0 : hw + 1;
    @(posedge clk);
    #1;
    chk("p_valid", p_valid, mp_v);
    chk("h_valid", h_valid, mh_v);
    chk("p_rdata", p_rdata, mp_d);
    chk("h_rdata", h_rdata, mh_d);
    if (use_tbl) begin
      chk("tbl_p_valid", p_valid, v.e_pv);
      chk("tbl_h_valid", h_valid, v.e_hv);
      chk("tbl_p_rdata", p_rdata, v.e_pv ? v.e_data : 32'd0);
      chk("tbl_h_rdata", h_rdata, v.e_hv ? v.e_data : 32'd0);
      $display("row %0d: rst=%0b hlt=%0b p_req=%0b h_req=%0b -> stall=%0b gnt=%0b pv=%0b hv=%0b pd=%h hd=%h",
               idx, v.rst, v.halted, v.preq, v.hreq, v.e_stall, v.e_gnt,
               p_valid, h_valid, p_rdata, h_rdata);
    end
  endtask

  vec_t tbl [27];
  vec_t rv;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 32'hA5A5_0000 | i;
      shadow[i] = 32'hA5A5_0000 | i;
    end
    mem[5]    = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;

    tbl[0]  = mk(1,0, 0,0,0,0,         0,0,0,0,         0,0,0,0,0);
    tbl[1]  = mk(0,0, 1,0,5,0,         0,0,0,0,         0,0,1,0,32'hDEADBEEF);
    tbl[2]  = mk(0,0, 1,1,10'h0A,'h11, 1,0,10'h0A,0,    0,0,0,0,0);
    tbl[3]  = mk(0,0, 0,0,0,0,         1,0,10'h0A,0,    0,1,0,1,32'h11);
    tbl[4]  = mk(0,0, 0,0,0,0,         0,0,0,0,         0,0,0,0,0);
    for (int i = 5; i <= 8; i++)
      tbl[i] = mk(0,0, 1,0,1,0,        1,1,10'h20,'h55, 0,0,1,0,32'hA5A50001);
    tbl[9]  = mk(0,0, 1,0,1,0,         1,1,10'h20,'h55, 1,1,0,0,0);
    tbl[10] = mk(0,0, 1,0,1,0,         0,0,0,0,         0,0,1,0,32'hA5A50001);
    tbl[11] = mk(0,1, 1,0,1,0,         1,0,10'h3FF,0,   0,1,0,1,32'hA5A503FF);
    tbl[12] = mk(0,0, 0,0,0,0,         1,0,10'h20,0,    0,1,0,1,32'h55);
    tbl[13] = mk(1,0, 0,0,0,0,         1,0,5,0,         0,1,0,0,0);
    tbl[14] = mk(0,0, 0,0,0,0,         0,0,0,0,         0,0,0,0,0);
    tbl[15] = mk(0,0, 1,0,1,0,         1,0,3,0,         0,0,1,0,32'hA5A50001);
    tbl[16] = tbl[15];
    tbl[17] = mk(0,0, 1,0,1,0,         0,0,0,0,         0,0,1,0,32'hA5A50001);
    for (int i = 18; i <= 21; i++) tbl[i] = tbl[15];
    tbl[22] = mk(0,0, 1,0,1,0,         1,0,3,0,         1,1,0,1,32'hA5A50003);
    tbl[23] = mk(0,0, 1,0,1,0,         1,0,4,0,         0,0,1,0,32'hA5A50001);
    tbl[24] = mk(0,1, 1,0,1,0,         1,0,4,0,         0,1,0,1,32'hA5A50004);
    tbl[25] = mk(0,0, 1,0,1,0,         1,0,4,0,         0,0,1,0,32'hA5A50001);
    tbl[26] = mk(0,0, 0,0,0,0,         0,0,0,0,         0,0,0,0,0);

    for (int i = 0; i < 27; i++) cyc(tbl[i], 1'b1, i);

    // Random traffic over a small address window so read-after-write hits are frequent.
    for (int i = 0; i < 400; i++) begin
      rv = mk($urandom_range(0,49) == 0, $urandom_range(0,9) == 0,
              $urandom_range(0,3) != 0, 1'($urandom_range(0,1)),
              10'($urandom_range(0,15)), $urandom,
              1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
              10'($urandom_range(0,15)), $urandom,
              0,0,0,0,0);
      cyc(rv, 1'b0, i);
    end
    $display("random phase: 400 cycles applied");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
